// File: rtl/key_event_decoder_pkg.sv
// Shared state encodings and default tick constants for the key event path,
// reused by the debouncer top level and application logic.
package key_event_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_WAIT2  = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_LONG   = 3'd4
  } key_state_e;

  localparam int unsigned DEF_CNT_W        = 8;
  localparam int unsigned DEF_LONG_TICKS   = 100;
  localparam int unsigned DEF_DCLK_TICKS   = 30;
  localparam int unsigned DEF_REPEAT_TICKS = 20;

  typedef struct packed {
    logic click;
    logic dclick;
    logic long_p;
    logic rpt;
  } key_pulse_t;

endpackage

// File: rtl/key_event_decoder_btn_edge.sv
// Rise/fall detector for a debounced level. The history register resets to 1
// so a button already held when reset releases produces no rise.
module btn_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic rise_o,
  output logic fall_o
);

  logic btn_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) btn_q <= 1'b1;
    else         btn_q <= btn_i;
  end

  assign rise_o = btn_i & ~btn_q;
  assign fall_o = ~btn_i & btn_q;

endmodule

// File: rtl/key_event_decoder.sv
// Classifies debounced presses into click / double-click / long-press events
// with auto-repeat while held; all timing counted in clk_flag ticks.
//
//   state  | meaning
//   IDLE   | released, waiting for a press
//   PRESS1 | first press in progress, timing toward long press
//   WAIT2  | released after short press, timing the double-click window
//   PRESS2 | second press in progress, untimed
//   LONG   | long-hold, emitting repeat pulses
module key_event_decoder
  import key_event_decoder_pkg::*;
#(
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned LONG_TICKS   = 10,
  parameter int unsigned DCLK_TICKS   = 4,
  parameter int unsigned REPEAT_TICKS = 3
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clk_flag,
  input  logic i_btn,
  output logic o_click,
  output logic o_dclick,
  output logic o_long,
  output logic o_repeat,
  output logic o_held
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DCLK_LAST = CNT_W'(DCLK_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  key_pulse_t       pulse_d, pulse_q;
  logic             held_q;
  logic             rise, fall, tick;
  logic             long_hit, dclk_hit, rep_hit;

  btn_edge u_btn_edge (
    .clk_i  (sys_clk),
    .rst_ni (sys_rst_n),
    .btn_i  (i_btn),
    .rise_o (rise),
    .fall_o (fall)
  );

  // An edge coinciding with clk_flag swallows that tick.
  assign tick     = clk_flag & ~rise & ~fall;
  assign long_hit = tick & (cnt_q == LONG_LAST);
  assign dclk_hit = tick & (cnt_q == DCLK_LAST);
  assign rep_hit  = tick & (cnt_q == REP_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (rise) state_d = ST_PRESS1;
      ST_PRESS1: begin
        if (fall)          state_d = ST_WAIT2;
        else if (long_hit) state_d = ST_LONG;
      end
      ST_WAIT2: begin
        if (rise)          state_d = ST_PRESS2;
        else if (dclk_hit) state_d = ST_IDLE;
      end
      ST_PRESS2: if (fall) state_d = ST_IDLE;
      ST_LONG:   if (fall) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pulse_d        = '0;
    pulse_d.click  = (state_q == ST_WAIT2)  & ~rise & dclk_hit;
    pulse_d.dclick = (state_q == ST_PRESS2) & fall;
    pulse_d.long_p = (state_q == ST_PRESS1) & ~fall & long_hit;
    pulse_d.rpt    = (state_q == ST_LONG)   & ~fall & rep_hit;
  end

  // PRESS2 is untimed, so its counter is simply held.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q || pulse_d.rpt)
      cnt_d = '0;
    else if (tick && (state_q == ST_PRESS1 || state_q == ST_WAIT2 || state_q == ST_LONG))
      cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pulse_q <= '0;
      held_q  <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
      held_q  <= (state_d == ST_LONG);
    end
  end

  assign o_click  = pulse_q.click;
  assign o_dclick = pulse_q.dclick;
  assign o_long   = pulse_q.long_p;
  assign o_repeat = pulse_q.rpt;
  assign o_held   = held_q;

endmodule
